// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman bit packer slice.
//   NUM_SYM / SYM_MIN / SYM_MAX : legal gray symbol range and codebook size
//   OUT_W / BUF_W               : output byte width and bit accumulator width
//   code_t / len_t              : code word and code length types
//   state_t + St* constants     : packer FSM encoding
//   popcount8()                 : code length from a contiguous LSB mask
package huffman_pkg;

    localparam int unsigned NUM_SYM = 6;
    localparam int unsigned SYM_MIN = 1;
    localparam int unsigned SYM_MAX = 6;
    localparam int unsigned OUT_W   = 8;
    localparam int unsigned BUF_W   = 16;  // must stay >= 2*OUT_W

    typedef logic [7:0] code_t;
    typedef logic [3:0] len_t;

    typedef logic [1:0] state_t;
    localparam state_t StIdle  = 2'd0;
    localparam state_t StRun   = 2'd1;
    localparam state_t StFlush = 2'd2;
    localparam state_t StDone  = 2'd3;

    function automatic len_t popcount8(input code_t v);
        len_t c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + len_t'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/huffman_bitpacker_if.sv
// Handshake bundle for the Huffman bit packer.
//   codebook : code_valid, HC1..HC6 (code bits), M1..M6 (length masks)
//   symbols  : sym_valid / sym_data / sym_last in, sym_ready out
//   bytes    : out_valid / out_data / out_last out, out_ready in
//   status   : sym_err (sticky), done (pulse), total_bits (HUFF_BITCNT_EN only)
// Modport slave is the packer, master is the producer/consumer side.
interface huffman_bitpacker_if;
    import huffman_pkg::*;

    logic        code_valid;
    code_t       HC1, HC2, HC3, HC4, HC5, HC6;
    code_t       M1, M2, M3, M4, M5, M6;
    logic        sym_valid;
    logic [7:0]  sym_data;
    logic        sym_last;
    logic        sym_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready;
    logic        sym_err;
    logic        done;
`ifdef HUFF_BITCNT_EN
    logic [15:0] total_bits;
`endif

    modport slave (
        input  code_valid, HC1, HC2, HC3, HC4, HC5, HC6, M1, M2, M3, M4, M5, M6,
        input  sym_valid, sym_data, sym_last, out_ready,
        output sym_ready, out_valid, out_data, out_last, sym_err, done
`ifdef HUFF_BITCNT_EN
        , output total_bits
`endif
    );

    modport master (
        output code_valid, HC1, HC2, HC3, HC4, HC5, HC6, M1, M2, M3, M4, M5, M6,
        output sym_valid, sym_data, sym_last, out_ready,
        input  sym_ready, out_valid, out_data, out_last, sym_err, done
`ifdef HUFF_BITCNT_EN
        , input total_bits
`endif
    );

endinterface

// File: rtl/huff_code_lut.sv
// Codebook store: registers code = HC & M and len = popcount(M) for all six
// symbols when load_i is high, and looks up {code, len} for sym_i.
//   clk, reset : clock, synchronous active-high reset (clears the codebook)
//   load_i     : capture hc_i / mask_i (entry 0 = symbol 1)
//   sym_i      : gray symbol to look up
//   code_o     : right-aligned code bits (0 for illegal symbols)
//   len_o      : code length (0 for illegal symbols)
//   illegal_o  : sym_i outside SYM_MIN..SYM_MAX
module huff_code_lut
    import huffman_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_i,
    input  logic [NUM_SYM-1:0][7:0]   hc_i,
    input  logic [NUM_SYM-1:0][7:0]   mask_i,
    input  logic [7:0]                sym_i,
    output code_t                     code_o,
    output len_t                      len_o,
    output logic                      illegal_o
);

    logic [NUM_SYM-1:0][7:0] code_q, code_d;
    logic [NUM_SYM-1:0][3:0] len_q, len_d;

    always_comb begin
        code_d = code_q;
        len_d  = len_q;
        if (load_i) begin
            for (int n = 0; n < NUM_SYM; n++) begin
                code_d[n] = hc_i[n] & mask_i[n];
                len_d[n]  = popcount8(mask_i[n]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            code_q <= '0;
            len_q  <= '0;
        end else begin
            code_q <= code_d;
            len_q  <= len_d;
        end
    end

    always_comb begin
        code_o    = '0;
        len_o     = '0;
        illegal_o = 1'b1;
        if (sym_i >= 8'(SYM_MIN) && sym_i <= 8'(SYM_MAX)) begin
            illegal_o = 1'b0;
            code_o    = code_q[3'(sym_i - 8'(SYM_MIN))];
            len_o     = len_q[3'(sym_i - 8'(SYM_MIN))];
        end
    end

endmodule

// File: rtl/huffman_bitpacker.sv
// Huffman bit packer: latches the codebook on code_valid, maps gray symbols
// to variable-length codes and packs them MSB-first into bytes under a
// valid/ready handshake; the final byte is zero-padded and tagged out_last.
//   clk, reset : clock, synchronous active-high reset
//   bus        : huffman_bitpacker_if.slave (codebook, symbol and byte streams)
// Optional: define HUFF_BITCNT_EN to add bus.total_bits, a saturating count
// of code bits appended since the last codebook load.
module huffman_bitpacker
    import huffman_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    huffman_bitpacker_if.slave bus
);

    state_t             state_q, state_d;
    logic [BUF_W-1:0]   acc_q, acc_d;      // left-aligned: oldest bit at MSB
    logic [4:0]         bitcnt_q, bitcnt_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic               sym_err_q, sym_err_d;

    logic               lut_load, lut_illegal;
    code_t              lut_code;
    len_t               lut_len;
    logic               sym_ready, accept, slot_free;
    logic [BUF_W-1:0]   code_left;

    assign lut_load = (state_q == StIdle) && bus.code_valid;

    huff_code_lut u_lut (
        .clk       (clk),
        .reset     (reset),
        .load_i    (lut_load),
        .hc_i      ({bus.HC6, bus.HC5, bus.HC4, bus.HC3, bus.HC2, bus.HC1}),
        .mask_i    ({bus.M6, bus.M5, bus.M4, bus.M3, bus.M2, bus.M1}),
        .sym_i     (bus.sym_data),
        .code_o    (lut_code),
        .len_o     (lut_len),
        .illegal_o (lut_illegal)
    );

    assign sym_ready = (state_q == StRun) && (bitcnt_q < 5'(OUT_W));
    assign accept    = bus.sym_valid && sym_ready;
    assign slot_free = !out_valid_q || bus.out_ready;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        bitcnt_d    = bitcnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        sym_err_d   = sym_err_q;
        // Code moved to the top of the buffer; illegal symbols have len 0, code 0.
        code_left   = {lut_code, 8'h00} << (4'd8 - lut_len);

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (lut_load) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (slot_free && bitcnt_q >= 5'(OUT_W)) begin
                    out_data_d  = acc_q[BUF_W-1 -: OUT_W];
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    acc_d       = acc_q << OUT_W;
                    bitcnt_d    = bitcnt_q - 5'(OUT_W);
                end
                // Append after any shift so a same-cycle emit cannot lose bits.
                if (accept) begin
                    acc_d     = acc_d | (code_left >> bitcnt_d);
                    bitcnt_d  = bitcnt_d + 5'(lut_len);
                    sym_err_d = sym_err_q | lut_illegal;
                    if (bus.sym_last) begin
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                if (out_valid_q && out_last_q) begin
                    if (bus.out_ready) begin
                        state_d = StDone;
                    end
                end else if (slot_free) begin
                    out_data_d  = acc_q[BUF_W-1 -: OUT_W];
                    out_valid_d = 1'b1;
                    if (bitcnt_q >= 5'(OUT_W)) begin
                        out_last_d = (bitcnt_q == 5'(OUT_W));
                        acc_d      = acc_q << OUT_W;
                        bitcnt_d   = bitcnt_q - 5'(OUT_W);
                    end else begin
                        // Bits below bitcnt are already zero, so this is the pad.
                        out_last_d = 1'b1;
                        acc_d      = '0;
                        bitcnt_d   = '0;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            bitcnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            sym_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            bitcnt_q    <= bitcnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            sym_err_q   <= sym_err_d;
        end
    end

    assign bus.sym_ready = sym_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.sym_err   = sym_err_q;
    assign bus.done      = (state_q == StDone);

`ifdef HUFF_BITCNT_EN
    logic [15:0] total_q, total_d;
    logic [16:0] total_sum;

    always_comb begin
        total_sum = {1'b0, total_q} + 17'(lut_len);
        total_d   = total_q;
        if (lut_load) begin
            total_d = '0;
        end else if (accept) begin
            total_d = total_sum[16] ? 16'hFFFF : total_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    assign bus.total_bits = total_q;
`endif

endmodule

// File: tb/tb_huffman_bitpacker.sv
// Self-checking bench for huffman_bitpacker: table of symbol streams with
// hand-computed bytes, plus hand-written stall and mid-stream reset sequences.
module tb_huffman_bitpacker;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    huffman_bitpacker_if bus ();

    huffman_bitpacker dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Byte collector and done tracker, all sampled on the falling edge.
    logic [8:0] got[$];
    int cyc          = 0;
    int last_acc_cyc = -1;
    int done_cyc     = -1;
    int done_cnt     = 0;

    always @(negedge clk) begin
        cyc++;
        if (bus.out_valid && bus.out_ready) begin
            got.push_back({bus.out_last, bus.out_data});
            if (bus.out_last) last_acc_cyc = cyc;
        end
        if (bus.done) begin
            done_cyc = cyc;
            done_cnt++;
        end
    end

    typedef struct {
        int              n;
        logic [0:5][7:0] s;
        int              nb;
        logic [0:3][7:0] b;
        bit              err;
        int              bits;
    } vec_t;

    vec_t vecs[7];

    task automatic load_codebook();
        bus.code_valid = 1'b1;
        @(posedge clk); #1;
        bus.code_valid = 1'b0;
    endtask

    task automatic send_sym(input logic [7:0] s, input bit last);
        int t;
        bus.sym_valid = 1'b1;
        bus.sym_data  = s;
        bus.sym_last  = last;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.sym_ready && t < 200);
        if (!bus.sym_ready) check("sym_ready_timeout", 0, 1);
        @(posedge clk); #1;
        bus.sym_valid = 1'b0;
        bus.sym_last  = 1'b0;
    endtask

    task automatic stall_out();
        int  t;
        bit  stable;
        logic [7:0] held;
        t = 0;
        while (!bus.out_valid && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus.out_valid) begin
            check("stall_wait_timeout", 0, 1);
        end else begin
            bus.out_ready = 1'b0;
            held   = bus.out_data;
            stable = 1'b1;
            repeat (5) begin
                @(negedge clk);
                if (bus.out_data != held || !bus.out_valid) stable = 1'b0;
            end
            check("stall_data_stable", int'(stable), 1);
            check("stall_sym_ready_low", int'(bus.sym_ready), 0);
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
        end
    endtask

    task automatic run_vec(input int vi, input bit stall);
        int start;
        int t;
        got.delete();
        start = done_cnt;
        load_codebook();
        fork
            begin
                for (int i = 0; i < vecs[vi].n; i++) send_sym(vecs[vi].s[i], i == vecs[vi].n - 1);
            end
            begin
                if (stall) stall_out();
            end
        join
        t = 0;
        while (done_cnt == start && t < 300) begin
            @(negedge clk); #1;
            t++;
        end
        check($sformatf("v%0d_done_seen", vi), int'(done_cnt > start), 1);
        check($sformatf("v%0d_nbytes", vi), got.size(), vecs[vi].nb);
        for (int i = 0; i < vecs[vi].nb && i < got.size(); i++) begin
            check($sformatf("v%0d_byte%0d", vi, i), int'(got[i][7:0]), int'(vecs[vi].b[i]));
            check($sformatf("v%0d_last%0d", vi, i), int'(got[i][8]), int'(i == vecs[vi].nb - 1));
        end
        check($sformatf("v%0d_done_latency", vi), done_cyc - last_acc_cyc, 1);
        check($sformatf("v%0d_sym_err", vi), int'(bus.sym_err), int'(vecs[vi].err));
`ifdef HUFF_BITCNT_EN
        check($sformatf("v%0d_total_bits", vi), int'(bus.total_bits), vecs[vi].bits);
`endif
        @(negedge clk);
        check($sformatf("v%0d_done_width", vi), int'(bus.done), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        // Codes: 1='0' 2='10' 3='110' 4='1110' 5='11110' 6='11111'
        vecs[0] = '{n:3, s:{8'd1, 8'd2, 8'd3, 24'd0}, nb:1, b:{8'h58, 24'h0}, err:1'b0, bits:6};
        vecs[1] = '{n:2, s:{8'd6, 8'd6, 32'd0}, nb:2, b:{8'hFF, 8'hC0, 16'h0}, err:1'b0, bits:10};
        vecs[2] = '{n:2, s:{8'd4, 8'd4, 32'd0}, nb:1, b:{8'hEE, 24'h0}, err:1'b0, bits:8};
        vecs[3] = '{n:5, s:{8'd6, 8'd6, 8'd6, 8'd6, 8'd6, 8'd0}, nb:4,
                    b:{8'hFF, 8'hFF, 8'hFF, 8'h80}, err:1'b0, bits:25};
        vecs[4] = '{n:4, s:{8'd1, 8'd9, 8'd2, 8'd3, 16'd0}, nb:1, b:{8'h58, 24'h0},
                    err:1'b1, bits:6};
        vecs[5] = '{n:4, s:{8'd2, 8'd5, 8'd6, 8'd1, 16'd0}, nb:2, b:{8'hBD, 8'hF0, 16'h0},
                    err:1'b1, bits:13};
        vecs[6] = '{n:1, s:{8'd4, 40'd0}, nb:1, b:{8'hE0, 24'h0}, err:1'b0, bits:4};

        bus.code_valid = 1'b0;
        bus.HC1 = 8'd0;  bus.M1 = 8'd1;
        bus.HC2 = 8'd2;  bus.M2 = 8'd3;
        bus.HC3 = 8'd6;  bus.M3 = 8'd7;
        bus.HC4 = 8'd14; bus.M4 = 8'd15;
        bus.HC5 = 8'd30; bus.M5 = 8'd31;
        bus.HC6 = 8'd31; bus.M6 = 8'd31;
        bus.sym_valid = 1'b0;
        bus.sym_data  = 8'd0;
        bus.sym_last  = 1'b0;
        bus.out_ready = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_sym_ready", int'(bus.sym_ready), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        check("rst_out_last", int'(bus.out_last), 0);
        check("rst_sym_err", int'(bus.sym_err), 0);
        check("rst_done", int'(bus.done), 0);
        @(posedge clk); #1;

        for (int v = 0; v < 4; v++) run_vec(v, 1'b0);
        run_vec(3, 1'b1);   // same stream as vecs[3] with a 5-cycle output stall
        run_vec(4, 1'b0);
        run_vec(5, 1'b0);

        // Reset mid-stream with 5 bits buffered ('10' + '110').
        got.delete();
        load_codebook();
        send_sym(8'd2, 1'b0);
        send_sym(8'd3, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_sym_ready", int'(bus.sym_ready), 0);
        check("mid_rst_out_valid", int'(bus.out_valid), 0);
        check("mid_rst_out_data", int'(bus.out_data), 0);
        check("mid_rst_out_last", int'(bus.out_last), 0);
        check("mid_rst_sym_err", int'(bus.sym_err), 0);
        check("mid_rst_done", int'(bus.done), 0);
        repeat (3) @(negedge clk);
        check("mid_rst_no_bytes", got.size(), 0);
        check("mid_rst_idle_ready", int'(bus.sym_ready), 0);
        @(posedge clk); #1;
        run_vec(6, 1'b0);   // stale bits would corrupt 0xE0

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/huffman_bitpacker.md
Name: huffman_bitpacker

Overview:
- Downstream stage of the Huffman encoder.
- Latches the six-entry codebook (HC1..HC6 / M1..M6) when the encoder pulses code_valid.
- Then accepts a stream of gray symbols 1..6, maps each one to its variable-length code and packs the codes MSB-first into 8-bit output bytes under a valid/ready handshake.
- Zero-pads and tags the final byte when the caller marks the last symbol.

Parameters:
- OUT_W, 8, output word width in bits; fixed at 8, the parameter exists for readability only.
- BUF_W, 16, width of the internal bit accumulator; must be >= 2*OUT_W.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high; clock clk
- code_valid  in  1  one-cycle pulse: HC1..HC6 and M1..M6 are valid
- HC1..HC6  in  8 each  code bits, right-aligned
- M1..M6  in  8 each  mask; contiguous ones from the LSB; code length = popcount, 1..8
- sym_valid  in  1  symbol present
- sym_data  in  8  gray symbol; 1..6 are legal
- sym_last  in  1  qualifies the final symbol of the stream
- sym_ready  out  1  block can accept a symbol this cycle
- out_valid  out  1  out_data holds a packed byte
- out_data  out  8  packed bits; first code bit is in bit 7
- out_last  out  1  final byte of the stream
- out_ready  in  1  consumer accepts the byte
- sym_err  out  1  sticky: an illegal symbol was seen
- done  out  1  one-cycle pulse after the last byte is accepted

Behaviour:
- Reset values: all outputs 0; accumulator, bit count, codebook and state cleared.
- Reset taken mid-stream discards all partial bits without emitting anything.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE: sym_ready=0. On code_valid, latch len[n]=popcount(Mn) and code[n]=HCn&Mn, then go to RUN.
  - RUN: code_valid is ignored.
  - DONE: assert done for 1 cycle, then go to IDLE. The codebook is kept; a new code_valid reloads it.
- Symbol accept: sym_ready = (state==RUN) && (bitcnt < 8). A transfer occurs when sym_valid && sym_ready.
- Appending a code: the code's bits are placed below the existing bits of the left-aligned accumulator, and bitcnt += len. The bound bitcnt <= 15 guarantees no overflow.
- Illegal symbols (0, 7..255): consumed, append no bits, set sym_err. sym_err clears only on reset.
- Output: when !out_valid or out_ready, and bitcnt >= 8:
  - load out_data = accumulator[15:8];
  - shift the accumulator left by 8; bitcnt -= 8;
  - out_valid=1 on the next cycle.
- Output hold: while out_valid && !out_ready, out_data and out_last are held stable.
- Same-cycle accept and emit: if a symbol is accepted in the same cycle a byte is emitted, the new bits are appended after the shift. No bits may be lost or duplicated.
- Latency: a byte becomes valid 1 cycle after bitcnt reaches >= 8.
- sym_last accepted: go to FLUSH; sym_ready=0.
- FLUSH:
  - Drain full bytes first.
  - If 0 < bitcnt < 8, emit accumulator[15:8] with the low bits zero-padded and out_last=1.
  - If bitcnt == 0 after the final full byte, that final full byte carries out_last=1.
  - If the stream produced no bits at all, emit 0x00 with out_last=1.
  - Go to DONE when the out_last byte is accepted.
- Codes are taken as given; this block does not check that the codebook is prefix-free.

Optional Feature:
- Macro: HUFF_BITCNT_EN.
- Defined:
  - adds output total_bits (16), the unpadded count of code bits appended since the last code_valid;
  - total_bits saturates at 16'hFFFF and is valid when done pulses.
- Undefined: the port and its counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package huffman_pkg:
  - NUM_SYM=6;
  - SYM_MIN=1, SYM_MAX=6;
  - OUT_W;
  - typedef code_t (8 bits);
  - typedef len_t (4 bits);
  - FSM state enum.
- One natural sub-module, huff_code_lut: registers the codebook on code_valid and gives combinational {code,len} for a symbol index, plus an illegal flag.
- Packing and the FSM stay in the top module.

Test Plan:
- Codebook used in the scenarios below: M1=1 HC1=0, M2=3 HC2=2, M3=7 HC3=6, M4=15 HC4=14, M5=31 HC5=30, M6=31 HC6=31.
- Scenario 1: load the codebook, send symbols 1,2,3 with last on 3 -> one byte 0x58, out_last=1, done pulses 1 cycle after it is accepted.
- Scenario 2: symbols 6,6 with last on the second -> bytes 0xFF then 0xC0 (last); total_bits=10 with HUFF_BITCNT_EN.
- Scenario 3: symbols 4,4 with last -> exactly one byte 0xEE with out_last=1 and no extra zero byte.
- Scenario 4: out_ready held low for 5 cycles while symbols stream -> out_data stable, sym_ready drops once bitcnt >= 8, byte sequence identical to the no-stall run.
- Scenario 5: symbol 9 mid-stream -> sym_err=1 and stays 1, output bytes identical to the stream without the 9.
- Scenario 6: reset asserted in RUN with 5 bits buffered -> no byte emitted; all outputs 0; sym_ready=0 until the next code_valid.
